// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 codes, access sizes, pipeline stage type and lane helpers for dmem_lsu
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} size_e;

  typedef struct packed {
    logic        valid;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        we;
    logic        fault;
    logic [31:0] word;
  } stage_t;

  // Unsigned variants only exist for loads; stores with those codes are illegal.
  function automatic size_e access_size(input logic we, input logic [2:0] funct3);
    size_e sz;
    case (funct3)
      F3_B:    sz = SZ_BYTE;
      F3_H:    sz = SZ_HALF;
      F3_W:    sz = SZ_WORD;
      F3_BU:   sz = we ? SZ_ILL : SZ_BYTE;
      F3_HU:   sz = we ? SZ_ILL : SZ_HALF;
      default: sz = SZ_ILL;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input size_e sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = !off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response handshake bundle between the MEM stage and dmem_lsu
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_fmt.sv
// rtl/dmem_fmt.sv - load lane extraction with sign/zero extension on the last response stage
module dmem_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic        kill,
  output logic [31:0] rdata
);
  logic [31:0] sh;

  always_comb begin
    sh    = word >> {off, 3'b000};
    rdata = '0;
    if (!kill) begin
      case (funct3)
        F3_B:    rdata = {{24{sh[7]}}, sh[7:0]};
        F3_H:    rdata = {{16{sh[15]}}, sh[15:0]};
        F3_W:    rdata = sh;
        F3_BU:   rdata = {24'h0, sh[7:0]};
        F3_HU:   rdata = {16'h0, sh[15:0]};
        default: rdata = '0;
      endcase
    end
  end
endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I data memory with load/store formatting, fault checks and post-reset clear
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus,
  output logic       init_done
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  stage_t            stage_q [LATENCY];
  stage_t            stage_d [LATENCY];
  logic [31:0]       mem_q [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  size_e             sz;
  logic              fault, stall, ready, accept;
  logic [3:0]        mask;
  logic [31:0]       rd_word, wsh, merged;

  assign addr  = bus.req_addr;
  assign idx   = addr[IDX_W+1:2];
  assign off   = addr[1:0];
  assign sz    = access_size(bus.req_we, bus.req_funct3);
  // Any address bit above the word index makes the access out of range.
  assign fault = !is_aligned(sz, off) || (|(addr >> (IDX_W + 2)));
  assign mask  = lane_mask(sz, off);

  assign stall  = stage_q[LATENCY-1].valid && !bus.rsp_ready;
  assign ready  = (state_q == ST_RUN) && !stall;
  assign accept = bus.req_valid && ready;

  assign rd_word = mem_q[idx];
  assign wsh     = bus.req_wdata << {off, 3'b000};

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merged[8*b +: 8] = wsh[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_wdata = merged;
    stage_d   = stage_q;

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end else if (accept && bus.req_we && !fault && !rst) begin
      mem_we = 1'b1;
    end

    // A stalled response freezes the whole pipe, bubbles included.
    if (!stall) begin
      for (int i = LATENCY - 1; i > 0; i--) stage_d[i] = stage_q[i-1];
      stage_d[0] = '0;
      if (accept) begin
        stage_d[0].valid  = 1'b1;
        stage_d[0].funct3 = bus.req_funct3;
        stage_d[0].off    = off;
        stage_d[0].we     = bus.req_we;
        stage_d[0].fault  = fault;
        stage_d[0].word   = rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  dmem_fmt u_fmt (
    .funct3 (stage_q[LATENCY-1].funct3),
    .off    (stage_q[LATENCY-1].off),
    .word   (stage_q[LATENCY-1].word),
    .kill   (stage_q[LATENCY-1].we || stage_q[LATENCY-1].fault),
    .rdata  (bus.rsp_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = stage_q[LATENCY-1].valid;
  assign bus.rsp_fault = stage_q[LATENCY-1].fault;
  assign init_done     = (state_q == ST_RUN);
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - scoreboard bench for dmem_lsu with a byte-array reference model
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int DEPTH = 128;
  localparam int LAT   = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    bit          exact;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic init_done;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 0;
  exp_t exp_q[$];
  logic [7:0] ref_mem [DEPTH*4];

  dmem_lsu_if #(.ADDR_W(32)) bus ();

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int size = 0;
    bit sgn = 0;
    bit legal = 1;
    logic [31:0] v = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: legal = 0;
    endcase
    if (we && f3 > 3'd2) legal = 0;
    if (legal && (addr % size) != 0) legal = 0;
    if (addr >= DEPTH * 4) legal = 0;
    flt = !legal;
    rd  = 0;
    if (legal) begin
      for (int b = 0; b < size; b++) begin
        if (we) ref_mem[addr + b] = wd[8*b +: 8];
        else    v = v | (32'(ref_mem[addr + b]) << (8 * b));
      end
      if (!we) begin
        if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit exact, input bit use_c,
                       input logic [31:0] c_rd, input logic c_flt);
    exp_t e;
    logic [31:0] m_rd;
    logic m_flt;
    bit acc = 0;
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    while (!acc && n < 1000) begin
      #1;
      acc   = bus.req_ready;
      e.acc = cyc;
      @(posedge clk);
      if (!acc) begin @(negedge clk); n++; end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted addr=%h", addr);
    end else begin
      model(we, f3, addr, wd, m_rd, m_flt);
      e.rdata = use_c ? c_rd : m_rd;
      e.fault = use_c ? c_flt : m_flt;
      e.exact = exact;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    bit lo_ok = 1;
    @(negedge clk);
    rst = 1; bus.req_valid = 0;
    exp_q.delete();
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_fault, init_done, bus.rsp_rdata[27:0]}, 32'd0);
    rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (bus.req_ready !== 1'b0 || init_done !== 1'b0) lo_ok = 0;
    end
    chk("clear_ready_low", 32'(lo_ok), 32'd1);
    @(negedge clk); #1;
    chk("clear_done_ready", {30'd0, bus.req_ready, init_done}, 32'd3);
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=rsp_valid required=no_response rdata=%h", bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
          if (e.exact) chk("rsp_latency", 32'(cyc - e.acc), 32'(LAT));
        end
      end
    end
  end

  initial begin
    bit stall_ok;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1;

    do_reset();
    issue(0, F3_W, 32'h1FC, 0, 1, 1, 32'h0, 0);

    issue(1, F3_W,  32'h10, 32'h8899AABB, 1, 1, 32'h0, 0);
    issue(0, F3_B,  32'h13, 0, 1, 1, 32'hFFFFFF88, 0);
    issue(0, F3_BU, 32'h12, 0, 1, 1, 32'h00000099, 0);
    issue(0, F3_H,  32'h10, 0, 1, 1, 32'hFFFFAABB, 0);
    issue(0, F3_HU, 32'h12, 0, 1, 1, 32'h00008899, 0);

    issue(1, F3_W, 32'h20, 32'h11223344, 1, 1, 32'h0, 0);
    issue(1, F3_B, 32'h21, 32'h0000005A, 1, 1, 32'h0, 0);
    issue(0, F3_W, 32'h20, 0, 1, 1, 32'h11225A44, 0);

    issue(0, F3_H,  32'h31, 0, 1, 1, 32'h0, 1);
    issue(1, F3_W,  32'h30, 32'h01020304, 1, 1, 32'h0, 0);
    issue(1, F3_W,  32'h32, 32'hFFFFFFFF, 1, 1, 32'h0, 1);
    issue(0, F3_W,  32'h30, 0, 1, 1, 32'h01020304, 0);
    issue(0, F3_W,  32'h200, 0, 1, 1, 32'h0, 1);
    issue(0, 3'b011, 32'h0, 0, 1, 1, 32'h0, 1);
    issue(1, F3_BU, 32'h30, 32'h77, 1, 1, 32'h0, 1);
    idle();
    drain();

    // Stall: three loads in flight, a store held on the bus while the response is blocked.
    @(negedge clk); bus.rsp_ready = 0;
    issue(0, F3_W,  32'h10, 0, 0, 1, 32'h8899AABB, 0);
    issue(0, F3_B,  32'h13, 0, 0, 1, 32'hFFFFFF88, 0);
    issue(0, F3_HU, 32'h12, 0, 0, 1, 32'h00008899, 0);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h10; bus.req_wdata = 32'hDEADBEEF;
    stall_ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
          bus.rsp_rdata !== 32'h8899AABB || bus.rsp_fault !== 1'b0) stall_ok = 0;
    end
    chk("stall_hold", 32'(stall_ok), 32'd1);
    @(negedge clk); bus.req_valid = 0; bus.rsp_ready = 1;
    issue(0, F3_W, 32'h10, 0, 0, 1, 32'h8899AABB, 0);
    idle();
    drain();

    rand_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = $urandom_range(0, 63);
      else if (r == 8) a = 32'h1F8 + $urandom_range(0, 15);
      else             a = $urandom;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0, 0, 32'h0, 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    @(negedge clk); rand_rdy = 0; bus.rsp_ready = 1;
    drain();

    // Reset with loads in flight: they vanish and the array is re-zeroed.
    issue(1, F3_W, 32'h40, 32'h12345678, 0, 1, 32'h0, 0);
    issue(0, F3_W, 32'h40, 0, 0, 1, 32'h12345678, 0);
    idle();
    drain();
    issue(0, F3_W, 32'h40, 0, 0, 1, 32'h12345678, 0);
    issue(0, F3_W, 32'h10, 0, 0, 1, 32'h8899AABB, 0);
    do_reset();
    issue(0, F3_W, 32'h40, 0, 1, 1, 32'h0, 0);
    issue(0, F3_W, 32'h10, 0, 1, 1, 32'h0, 0);
    idle();
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
